// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
//   show-ahead FIFO that is read through a valid/ready stream.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : 8E1 frames, even parity checked, parity_err live
//     undefined : 8N1 frames, parity_err tied to 0
//
// Ports
//   CLK100MHZ   in   clock for the whole block
//   CPU_RESETN  in   asynchronous active-low reset
//   rxd         in   asynchronous serial input, idles high
//   m_data      out  byte at the FIFO head (valid while m_valid)
//   m_valid     out  FIFO not empty
//   m_ready     in   consumer accepts the head byte
//   fifo_count  out  number of bytes stored
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   overrun     out  1-cycle pulse: good byte dropped, FIFO full
//   parity_err  out  1-cycle pulse: wrong parity (0 without the macro)
//------------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                            CLK100MHZ,
   input  logic                            CPU_RESETN,
   input  logic                            rxd,
   output logic [7:0]                      m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            frame_err,
   output logic                            overrun,
   output logic                            parity_err
);

   // Rounded divide: oversample clock is 16x the baud rate.
   localparam int unsigned DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // Synchroniser and edge detect
   logic             r_sync1;
   logic             r_sync2;
   logic             r_rxs_d;
   logic             w_rxs;
   logic             w_fall;

   // Receiver
   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_tick;
   logic [3:0]       r_tick_cnt;
   logic             w_mid_bit;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             w_tick_clr;
   logic             w_shift_en;
   logic             w_push;
   logic             w_ferr;
   logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic             w_par_chk;
   logic             w_perr;
   logic             r_par_bad;
   logic             r_parity_err;
`endif

   // FIFO
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] w_rd_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_full;
   logic             w_pop;
   logic             w_wr_en;
   logic [7:0]       r_m_data;
   logic [7:0]       w_head_nxt;
   logic             r_m_valid;
   logic             r_overrun;

   //---------------------------------------------------------------------------
   // Input synchroniser
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         r_rxs_d <= r_sync2;
      end
   end

   assign w_rxs  = r_sync2;
   assign w_fall = r_rxs_d & ~w_rxs;

   //---------------------------------------------------------------------------
   // Oversample tick; held at 0 in IDLE so every frame starts phase-aligned
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_div_cnt <= '0;
      end else if (r_state == S_IDLE || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
   assign w_mid_bit = w_tick && (r_tick_cnt == 4'd15);

   //---------------------------------------------------------------------------
   // Receive FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Receive FSM: next state and control strobes
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_tick_clr  = 1'b0;
      w_shift_en  = 1'b0;
      w_push      = 1'b0;
      w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_chk   = 1'b0;
      w_perr      = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            // Mid start bit after 8 ticks; realign sub-counter to bit cells.
            if (w_tick && r_tick_cnt == 4'd7) begin
               w_tick_clr  = 1'b1;
               w_state_nxt = w_rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_mid_bit) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_mid_bit) begin
               w_par_chk   = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_mid_bit) begin
               if (!w_rxs) begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_WAIT_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (r_par_bad) begin
                     w_perr = 1'b1;
                  end else begin
                     w_push = 1'b1;
                  end
`else
                  w_push = 1'b1;
`endif
               end
            end
         end
         S_WAIT_IDLE: begin
            // A held-low line (break) must not look like a new start bit.
            if (w_rxs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Receive datapath
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_tick_cnt  <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE || w_tick_clr) begin
            r_tick_cnt <= '0;
         end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
         end

         if (r_state == S_IDLE) begin
            r_bit_idx <= '0;
         end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end

         // LSB first: each new bit enters at the top and moves down.
         if (w_shift_en) begin
            r_shift <= {w_rxs, r_shift[7:1]};
         end

         r_frame_err <= w_ferr;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_par_bad <= 1'b0;
         end else if (w_par_chk) begin
            r_par_bad <= (w_rxs != (^r_shift));
         end
         r_parity_err <= w_perr;
      end
   end

   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // FIFO
   //---------------------------------------------------------------------------
   assign w_pop   = r_m_valid & m_ready;
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_wr_en = w_push & (~w_full | w_pop);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_en, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   assign w_rd_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

   // m_data is registered, so the next head is predicted here. When the
   // write lands on the next head slot (FIFO empty after this cycle's pop)
   // the incoming byte is forwarded instead of reading the stale entry.
   always_comb begin
      w_head_nxt = r_m_data;
      if (w_count_nxt != '0) begin
         if (w_wr_en && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = r_shift;
         end else begin
            w_head_nxt = r_mem[w_rd_nxt];
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr  <= w_rd_nxt;
         r_count   <= w_count_nxt;
         r_m_data  <= w_head_nxt;
         r_m_valid <= (w_count_nxt != '0);
         r_overrun <= w_push & w_full & ~w_pop;
      end
   end

   assign m_data     = r_m_data;
   assign m_valid    = r_m_valid;
   assign fifo_count = r_count;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a small output FIFO. It deserialises 8-bit asynchronous frames arriving on the board's UART input pin and presents the received bytes to the CPU-side bus logic through a valid/ready stream. It is the receive-side counterpart of the existing UART transmit path and sits inside the CPU block design between the `uart_rxd` pin and the memory-mapped UART register slave.

## Interface

Parameters:
- `CLK_FREQ`, default 100000000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 16: number of bytes the FIFO holds. Must be a power of two, at least 2.

Ports:
- `CLK100MHZ`, in, 1: single clock for the whole block.
- `CPU_RESETN`, in, 1: reset, asynchronous assert, active-low.
- `rxd`, in, 1: serial input, asynchronous to the clock, idles high.
- `m_data`, out, 8: byte at the FIFO head, valid only while `m_valid` = 1.
- `m_valid`, out, 1: FIFO is not empty.
- `m_ready`, in, 1: consumer accepts the head byte.
- `fifo_count`, out, $clog2(FIFO_DEPTH+1): number of bytes currently stored.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err`, out, 1: one-cycle pulse when received parity is wrong. Tied to 0 when parity is compiled out.

## Operation

- **Input synchroniser.** `rxd` passes through two flops, preset to 1 on reset. All logic uses the synchronised value `rxs`.
- **Oversample tick.**
  - `DIV` = round(CLK_FREQ / (BAUD*16)), which is 54 at the defaults.
  - A counter runs 0..DIV-1 and emits `tick` on wrap.
  - The counter is held at 0 in IDLE, so a frame starts phase-aligned.
- **State machine.** States are IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
  - IDLE: a falling edge on `rxs` moves to START and clears the tick sub-counter.
  - START: after 8 ticks (mid-bit), sample `rxs`.
    - If 1, this is a false start; return to IDLE.
    - If 0, go to DATA.
  - DATA: every 16 ticks, sample one bit LSB-first into the shift register. After bit 7, go to PARITY if it is compiled in, otherwise go to STOP.
  - PARITY: after 16 ticks, sample `rxs` and compare it with the even parity of the 8 data bits. Then go to STOP.
  - STOP: after 16 ticks, sample `rxs`.
    - If 1 and parity was good, push the byte and go to IDLE.
    - If 1 and parity was bad, pulse `parity_err`, discard the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, then go to IDLE. This prevents a break condition from being retriggered as a new start.
- **FIFO.**
  - Show-ahead: `m_data` always reflects the head entry.
  - Pop: on a cycle where `m_valid` and `m_ready` are both 1.
  - Push: the good byte from STOP.
  - Push when full with no pop in the same cycle: drop the byte and pulse `overrun`.
  - Push when full with a pop in the same cycle: the push is accepted and `fifo_count` stays unchanged.
  - Push and pop on a non-empty FIFO: `fifo_count` is unchanged.
  - Push when empty: `m_valid` rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing

- **Reset.** While `CPU_RESETN` = 0:
  - `m_valid`, `frame_err`, `overrun`, `parity_err` = 0.
  - `fifo_count` = 0, FIFO pointers = 0, `m_data` = 0.
  - State = IDLE, synchroniser = 1.
- **Reset mid-frame.** The partial byte is lost. Reception resumes at the next falling edge after release.
- **Latencies.**
  - `rxd` to `rxs`: 2 cycles.
  - Stop-bit mid-sample to `m_valid` (empty FIFO): 1 cycle.
  - Error pulses are asserted in the cycle after the deciding sample, for exactly 1 cycle.
- **Bit period.** 16×DIV cycles, which is 864 at the defaults. Sampling is at mid-bit.
- **Tolerance.** Baud mismatch of up to ±2% must be tolerated.
- **Output timing.** `m_data` and `m_valid` are registered outputs. `m_ready` may be combinational from the consumer.

## Configuration

- **Macro `UART_RX_PARITY_EN`.**
  - Defined: frames are 8E1. The PARITY state is present, even parity is checked, and `parity_err` is live.
  - Undefined: frames are 8N1. The PARITY state and its logic are removed, and `parity_err` is constant 0.

## Test plan

All scenarios use the default parameters (100 MHz, 115200 baud, 864 cycles per bit).

- **Single byte.** Send 0x55 as 8N1 with `m_ready` = 1. Expect exactly one `m_valid` cycle with `m_data` = 0x55. `frame_err`, `overrun` and `parity_err` stay 0.
- **Fill and overrun.** Hold `m_ready` = 0 and send bytes 0x00..0x10 (17 frames). Expect `fifo_count` to reach 16 and one `overrun` pulse on the 17th frame. Draining then yields 0x00..0x0F in order, and `fifo_count` returns to 0.
- **Framing error.** Send 0xA5 with the stop bit forced low for a full bit, then idle. Expect one `frame_err` pulse and `fifo_count` unchanged. A following 0x5A must be received correctly.
- **Glitch rejection.** Pull `rxd` low for 200 cycles (less than the half-bit of 432). Expect no push, no error pulse, and the state back in IDLE.
- **Reset mid-frame.** Assert `CPU_RESETN` during data bit 3 of a frame. Expect all outputs to be at their reset values. After release, a full frame 0x3C is received as 0x3C.
- **Parity (only with `UART_RX_PARITY_EN`).** Send 0x81 with the parity bit set to 1 (wrong parity). Expect one `parity_err` pulse and no push. The same byte with parity bit 0 is accepted as 0x81.
